// File: rtl/dmem_bus_pkg.sv
// Shared types for the data-memory bus adapter: FSM state encoding,
// request record and default timeout depth.
package dmem_bus_pkg;

    localparam int unsigned DMEM_ADDR_WIDTH     = 32;
    localparam int unsigned DMEM_DATA_WIDTH     = 32;
    localparam int unsigned DMEM_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_bus_state_e;

    // Request record at the default core widths; the adapter builds a
    // width-parameterised twin with the same field order.
    typedef struct packed {
        logic [DMEM_ADDR_WIDTH-1:0]   addr;
        logic                         write;
        logic [DMEM_DATA_WIDTH-1:0]   wdata;
        logic [DMEM_DATA_WIDTH/8-1:0] wstrb;
    } dmem_req_t;

endpackage

// File: rtl/dmem_bus_adapter.sv
// Bridges the single-cycle core's combinational dmem port onto a registered
// valid/ready request channel and a valid-only response channel. core_stall
// freezes the core until the access retires in DONE, so every load/store
// reaches the bus exactly once.
// Optional: define DMEM_TIMEOUT_EN to force completion (with error) after
// TIMEOUT_CYCLES cycles in WAIT without a response.
module dmem_bus_adapter
    import dmem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DMEM_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_wstrb,
    input  logic                    core_write,
    input  logic                    core_read,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_stall,
    output logic                    bus_req_valid,
    input  logic                    bus_req_ready,
    output logic [ADDR_WIDTH-1:0]   bus_req_addr,
    output logic                    bus_req_write,
    output logic [DATA_WIDTH-1:0]   bus_req_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
    input  logic                    bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata,
    input  logic                    bus_rsp_err,
    output logic                    err_sticky
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned TMO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

    typedef logic [TMO_WIDTH-1:0] tmo_cnt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } req_t;

    dmem_bus_state_e       state_q, state_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

`ifdef DMEM_TIMEOUT_EN
    tmo_cnt_t tmo_q, tmo_d;
    logic     tmo_hit;

    // tmo_q counts completed WAIT cycles, so the current cycle is number
    // tmo_q+1; firing at TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit = (tmo_q == tmo_cnt_t'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, request capture, response handling and channel outputs.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        core_stall    = 1'b0;
        bus_req_valid = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                // The stall must be combinational so the core does not
                // retire this instruction at the upcoming edge.
                core_stall = core_read | core_write;
                if (core_read || core_write) begin
                    req_d.addr  = core_addr;
                    req_d.write = core_write;          // read+write => store
                    req_d.wdata = core_wdata;
                    req_d.wstrb = core_write ? core_wstrb : '0;
                    state_d     = REQ;
                end
            end

            REQ: begin
                bus_req_valid = 1'b1;
                core_stall    = 1'b1;
                if (bus_req_ready) begin
                    state_d = WAIT;
`ifdef DMEM_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end

            WAIT: begin
                core_stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                tmo_d      = tmo_q + tmo_cnt_t'(1);
`endif
                // A response in the timeout cycle takes priority.
                if (bus_rsp_valid) begin
                    if (!req_q.write) begin
                        rdata_d = bus_rsp_rdata;
                    end
                    if (bus_rsp_err) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    if (!req_q.write) begin
                        rdata_d = '0;
                    end
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                // Core retires here; the next access is sampled in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus_req_addr  = req_q.addr;
    assign bus_req_write = req_q.write;
    assign bus_req_wdata = req_q.wdata;
    assign bus_req_wstrb = req_q.wstrb;
    assign core_rdata    = rdata_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Self-checking bench for dmem_bus_adapter. Expected bus requests and
// expected retire data are queued when an access is driven and popped when
// the handshake / retirement is observed. Build with DMEM_TIMEOUT_EN to
// exercise the forced-completion path.
module tb_dmem_bus_adapter;

    localparam int TMO = 8;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_s;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wstrb;
    logic        core_write;
    logic        core_read;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_write;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;
    logic        err_sticky;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    req_s        exp_req_q[$];
    logic [31:0] exp_rdata_q[$];
    logic [31:0] model_rdata = 32'h0;

    dmem_bus_adapter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_wstrb   (core_wstrb),
        .core_write   (core_write),
        .core_read    (core_read),
        .core_rdata   (core_rdata),
        .core_stall   (core_stall),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_addr (bus_req_addr),
        .bus_req_write(bus_req_write),
        .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err  (bus_rsp_err),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            core_read  = 1'b0;
            core_write = 1'b0;
        end
    endtask

    // Drives one access through to retirement with a cooperative bus.
    task automatic run_access(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic [31:0] rsp_data, input logic rsp_err,
                              input int ready_delay, output int stalls,
                              output int valid_cycles, output int start_cyc,
                              output int done_cyc);
        req_s        e;
        req_s        p;
        logic [31:0] er;
        int          hs_n;
        bit          hs_pend;
        bit          done;
        e.addr  = addr;
        e.write = wr;
        e.wdata = wdata;
        e.wstrb = wr ? strb : 4'h0;
        exp_req_q.push_back(e);
        if (!wr) model_rdata = rsp_data;
        exp_rdata_q.push_back(model_rdata);

        @(posedge clk); #1;
        start_cyc     = cyc;
        core_read     = !wr;
        core_write    = wr;
        core_addr     = addr;
        core_wdata    = wdata;
        core_wstrb    = strb;
        bus_req_ready = (ready_delay == 0);
        stalls = 0; valid_cycles = 0; hs_n = 0; hs_pend = 0; done = 0; done_cyc = -1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!core_stall) begin
                done     = 1;
                done_cyc = cyc;
                er       = exp_rdata_q.pop_front();
                n_cmp++;
                if (core_rdata !== er) begin
                    n_bad++;
                    $display("FAIL %s rdata_at_done: got %h want %h", tag, core_rdata, er);
                end
            end else begin
                stalls++;
                if (bus_req_valid) begin
                    valid_cycles++;
                    n_cmp++;
                    if ({bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb} !==
                        {e.addr, e.write, e.wdata, e.wstrb}) begin
                        n_bad++;
                        $display("FAIL %s req_stable: got %h/%b/%h/%b want %h/%b/%h/%b", tag,
                                 bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb,
                                 e.addr, e.write, e.wdata, e.wstrb);
                    end
                    if (bus_req_ready) begin
                        hs_n++;
                        hs_pend = 1;
                        n_cmp++;
                        if (exp_req_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL %s handshake_unexpected: got addr %h want none", tag, bus_req_addr);
                        end else begin
                            p = exp_req_q.pop_front();
                            if ({bus_req_addr, bus_req_write, bus_req_wstrb} !== {p.addr, p.write, p.wstrb}) begin
                                n_bad++;
                                $display("FAIL %s handshake_req: got %h/%b/%b want %h/%b/%b", tag,
                                         bus_req_addr, bus_req_write, bus_req_wstrb, p.addr, p.write, p.wstrb);
                            end
                        end
                    end
                end
                @(posedge clk); #1;
                bus_rsp_valid = hs_pend;
                bus_rsp_rdata = hs_pend ? rsp_data : 32'h0;
                bus_rsp_err   = hs_pend ? rsp_err : 1'b0;
                hs_pend       = 0;
                bus_req_ready = (valid_cycles >= ready_delay);
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s retire_timeout: got no retire want retire within 64 cycles", tag);
        end
        n_cmp++;
        if (hs_n !== 1) begin
            n_bad++;
            $display("FAIL %s handshake_count: got %0d want 1", tag, hs_n);
        end
        $display("txn %s %s addr=%h stalls=%0d valid_cycles=%0d rdata=%h err=%b",
                 tag, wr ? "store" : "load", addr, stalls, valid_cycles, core_rdata, err_sticky);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_read = 0; core_write = 0; core_addr = 32'h0; core_wdata = 32'h0; core_wstrb = 4'h0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 32'h0; bus_rsp_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_req_valid, bus_req_write, bus_req_wstrb, core_stall, err_sticky} !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got v=%b w=%b s=%b st=%b e=%b want all 0",
                     bus_req_valid, bus_req_write, bus_req_wstrb, core_stall, err_sticky);
        end
        n_cmp++;
        if ({bus_req_addr, bus_req_wdata, core_rdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", bus_req_addr, bus_req_wdata, core_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_load();
        int st, vc, s0, d0;
        run_access("load", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0, st, vc, s0, d0);
        n_cmp++;
        if (st !== 3) begin n_bad++; $display("FAIL load_stall_cycles: got %0d want 3", st); end
        n_cmp++;
        if (d0 - s0 !== 3) begin n_bad++; $display("FAIL load_latency: got %0d want 3", d0 - s0); end
        n_cmp++;
        if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", err_sticky); end
        idle_cycles(1);
    endtask

    task automatic test_store_backpressure();
        int st, vc, s0, d0;
        run_access("store_bp", 1'b1, 32'h204, 32'h11223344, 4'b0011, 32'hCAFEF00D, 1'b0, 4, st, vc, s0, d0);
        n_cmp++;
        if (vc !== 5) begin n_bad++; $display("FAIL store_valid_cycles: got %0d want 5", vc); end
        n_cmp++;
        if (st !== 7) begin n_bad++; $display("FAIL store_stall_cycles: got %0d want 7", st); end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        int st1, vc1, s1, d1, st2, vc2, s2, d2;
        run_access("b2b_1", 1'b0, 32'h300, 32'h0, 4'h0, 32'h01020304, 1'b0, 0, st1, vc1, s1, d1);
        run_access("b2b_2", 1'b0, 32'h304, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0, 0, st2, vc2, s2, d2);
        n_cmp++;
        if (s2 !== d1 + 1) begin n_bad++; $display("FAIL b2b_issue_cycle: got %0d want %0d", s2, d1 + 1); end
        n_cmp++;
        if (d2 - s2 !== 3) begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", d2 - s2); end
        idle_cycles(1);
    endtask

    task automatic test_non_memory();
        int bad_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            core_read  = 1'b0;
            core_write = 1'b0;
            core_addr  = $urandom;
            core_wdata = $urandom;
            core_wstrb = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_cmp++;
            if (core_stall !== 1'b0 || bus_req_valid !== 1'b0) begin
                n_bad++;
                bad_cycles++;
                $display("FAIL nonmem_cycle%0d: got stall=%b valid=%b want 0/0", i, core_stall, bus_req_valid);
            end
        end
        $display("txn nonmem 10 cycles bad=%0d", bad_cycles);
    endtask

    task automatic test_error_reset();
        int st, vc, s0, d0;
        req_s e;
        req_s p;
        run_access("err_load", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0BADF00D, 1'b1, 0, st, vc, s0, d0);
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_sticky); end
        run_access("err_store", 1'b1, 32'h404, 32'h55667788, 4'hF, 32'h0, 1'b0, 1, st, vc, s0, d0);
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_sticky_hold: got %b want 1", err_sticky); end

        // Load abandoned by reset while in WAIT.
        e.addr = 32'h408; e.write = 1'b0; e.wdata = 32'h0; e.wstrb = 4'h0;
        exp_req_q.push_back(e);
        @(posedge clk); #1;
        core_read = 1'b1; core_write = 1'b0; core_addr = 32'h408; core_wdata = 32'h0; core_wstrb = 4'h0;
        bus_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (!(bus_req_valid && bus_req_ready)) begin
            n_bad++;
            $display("FAIL rst_req_handshake: got valid=%b want 1", bus_req_valid);
        end else begin
            p = exp_req_q.pop_front();
            if (bus_req_addr !== p.addr) begin
                n_bad++;
                $display("FAIL rst_req_addr: got %h want %h", bus_req_addr, p.addr);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        core_read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (core_stall !== 1'b1) begin n_bad++; $display("FAIL rst_in_wait_stall: got %b want 1", core_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus_req_valid, bus_req_write, bus_req_wstrb, core_stall, err_sticky} !== 8'h0 ||
            {bus_req_addr, bus_req_wdata, core_rdata} !== 96'h0) begin
            n_bad++;
            $display("FAIL rst_outputs: got v=%b addr=%h rdata=%h stall=%b err=%b want all 0",
                     bus_req_valid, bus_req_addr, core_rdata, core_stall, err_sticky);
        end
        @(posedge clk); #1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFFFFFF; bus_rsp_err = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (core_rdata !== 32'h0 || err_sticky !== 1'b0 || core_stall !== 1'b0 || bus_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_rsp_ignored: got rdata=%h err=%b stall=%b valid=%b want 0/0/0/0",
                     core_rdata, err_sticky, core_stall, bus_req_valid);
        end
        model_rdata = 32'h0;
        $display("txn reset_in_wait addr=00000408 rdata=%h err=%b", core_rdata, err_sticky);
    endtask

    task automatic test_timeout();
        int   st, vc, s0, d0, waits;
        bit   hs, done;
        req_s e;
        req_s p;
        run_access("pre_tmo", 1'b0, 32'h600, 32'h0, 4'h0, 32'h13579BDF, 1'b0, 0, st, vc, s0, d0);
        e.addr = 32'h500; e.write = 1'b0; e.wdata = 32'h0; e.wstrb = 4'h0;
        exp_req_q.push_back(e);
        @(posedge clk); #1;
        core_read = 1'b1; core_write = 1'b0; core_addr = 32'h500; core_wdata = 32'h0; core_wstrb = 4'hF;
        bus_req_ready = 1'b1;
        waits = 0; hs = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!core_stall) begin
                done = 1;
            end else if (bus_req_valid && bus_req_ready) begin
                hs = 1;
                p = exp_req_q.pop_front();
                n_cmp++;
                if (bus_req_addr !== p.addr || bus_req_wstrb !== p.wstrb) begin
                    n_bad++;
                    $display("FAIL tmo_req: got %h/%b want %h/%b", bus_req_addr, bus_req_wstrb, p.addr, p.wstrb);
                end
            end else if (hs) begin
                waits++;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
`ifdef DMEM_TIMEOUT_EN
        n_cmp++;
        if (!done || waits !== TMO) begin
            n_bad++;
            $display("FAIL tmo_wait_cycles: got done=%b waits=%0d want done=1 waits=%0d", done, waits, TMO);
        end
        n_cmp++;
        if (core_rdata !== 32'h0 || err_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_result: got rdata=%h err=%b want 00000000/1", core_rdata, err_sticky);
        end
        idle_cycles(1);
`else
        n_cmp++;
        if (done || waits !== 38) begin
            n_bad++;
            $display("FAIL tmo_hold_wait: got done=%b waits=%0d want done=0 waits=38", done, waits);
        end
        n_cmp++;
        if (core_rdata !== 32'h13579BDF || err_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_no_effect: got rdata=%h err=%b want 13579bdf/0", core_rdata, err_sticky);
        end
        rst = 1'b1;
        core_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        $display("txn timeout_load addr=00000500 waits=%0d rdata=%h err=%b", waits, core_rdata, err_sticky);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_backpressure();
        test_back_to_back();
        test_non_memory();
        test_error_reset();
        test_timeout();
        @(negedge clk);
        n_cmp++;
        if (exp_req_q.size() != 0 || exp_rdata_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got req=%0d rdata=%0d left want 0/0", exp_req_q.size(), exp_rdata_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
